// File: rtl/cdc_tx_arbiter.sv
// Source-domain front end for a shared bus+enable synchronizer: round-robin grant,
// stable transmit word, level enable under a four-phase handshake with a synchronized ack.
module cdc_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 7,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] data_in,
    input  logic                         ack_async,
    output logic [BUS_WIDTH-1:0]         tx_bus,
    output logic                         tx_enable,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           err,
    output logic [IDX_W-1:0]             owner,
    output logic                         busy,
    output logic [1:0]                   dbg_state,
    output logic [IDX_W-1:0]             dbg_rr_ptr
);

    // Four-phase handshake: tx_bus is stable before tx_enable rises and stays put;
    // enable stays high until the synchronized ack is seen high, then the next grant
    // waits until the synchronized ack has returned low.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t                r_state, w_state_nxt;
    logic [NUM_STAGES-1:0] r_ack_sync;
    logic [IDX_W-1:0]      r_rr_ptr, w_rr_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [BUS_WIDTH-1:0]  r_tx_bus, w_bus_nxt;
    logic                  r_tx_en, w_en_nxt;
    logic [IDX_W-1:0]      r_owner, w_owner_nxt;
    logic [NUM_REQ-1:0]    r_done, w_done_nxt;
    logic [NUM_REQ-1:0]    r_err, w_err_nxt;

    logic                  w_ack;
    logic [IDX_W:0]        w_pick;
    logic                  w_found;
    logic [IDX_W-1:0]      w_winner;
    logic [NUM_REQ-1:0]    w_owner_oh;
    logic                  w_timeout;

    // First set request at or above ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [IDX_W:0] f_pick(input logic [NUM_REQ-1:0] rq,
                                              input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (rq[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    assign w_ack      = r_ack_sync[NUM_STAGES-1];
    assign w_pick     = f_pick(req, r_rr_ptr);
    assign w_found    = w_pick[IDX_W];
    assign w_winner   = w_pick[IDX_W-1:0];
    assign w_owner_oh = NUM_REQ'(1) << r_owner;
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[NUM_STAGES-2:0], ack_async};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_tx_bus <= '0;
            r_tx_en  <= 1'b0;
            r_owner  <= '0;
            r_done   <= '0;
            r_err    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tx_bus <= w_bus_nxt;
            r_tx_en  <= w_en_nxt;
            r_owner  <= w_owner_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_cnt;
        w_bus_nxt   = r_tx_bus;
        w_en_nxt    = r_tx_en;
        w_owner_nxt = r_owner;
        w_done_nxt  = '0;
        w_err_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_bus_nxt   = data_in[w_winner*BUS_WIDTH +: BUS_WIDTH];
                    w_en_nxt    = 1'b1;
                    w_owner_nxt = w_winner;
                    w_rr_nxt    = (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + IDX_W'(1);
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // Ack is checked first so a late ack on the final count still completes.
                if (w_ack) begin
                    w_en_nxt    = 1'b0;
                    w_done_nxt  = w_owner_oh;
                    w_state_nxt = ST_RELEASE;
                end else if (w_timeout) begin
                    w_en_nxt    = 1'b0;
                    w_err_nxt   = w_owner_oh;
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!w_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign tx_bus     = r_tx_bus;
    assign tx_enable  = r_tx_en;
    assign done       = r_done;
    assign err        = r_err;
    assign owner      = r_owner;
    assign busy       = (r_state != ST_IDLE);
    assign dbg_state  = r_state;
    assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Directed bench for cdc_tx_arbiter: hand-computed grants, handshake latencies,
// timeout, ack/timeout collision and reset abort.
module tb_cdc_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int BUS_WIDTH  = 8;
    localparam int NUM_STAGES = 2;
    localparam int TIMEOUT    = 8;
    localparam int CNT_W      = 4;
    // Edges from an ack_async change at a negedge to the FSM reacting to it.
    localparam int ACK_LAT    = NUM_STAGES + 1;

    logic                         CLK = 1'b0;
    logic                         RST = 1'b0;
    logic [NUM_REQ-1:0]           req = '0;
    logic [NUM_REQ*BUS_WIDTH-1:0] data_in = '0;
    logic                         ack_async = 1'b0;
    logic [BUS_WIDTH-1:0]         tx_bus;
    logic                         tx_enable;
    logic [NUM_REQ-1:0]           done;
    logic [NUM_REQ-1:0]           err;
    logic [1:0]                   owner;
    logic                         busy;
    logic [1:0]                   dbg_state;
    logic [1:0]                   dbg_rr_ptr;

    int n_vec = 0;
    int n_err = 0;
    logic [BUS_WIDTH-1:0] exp_q[$];

    cdc_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .BUS_WIDTH(BUS_WIDTH), .NUM_STAGES(NUM_STAGES),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .data_in(data_in), .ack_async(ack_async),
        .tx_bus(tx_bus), .tx_enable(tx_enable), .done(done), .err(err),
        .owner(owner), .busy(busy), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_word(input int i, input logic [BUS_WIDTH-1:0] w);
        data_in[i*BUS_WIDTH +: BUS_WIDTH] = w;
    endtask

    task automatic wait_en(input logic lvl, input string tag, input int exp_n);
        int n = 0;
        while (tx_enable !== lvl && n < 40) begin
            tick();
            n++;
        end
        check(tag, n, exp_n);
    endtask

    task automatic wait_idle(input string tag, input int exp_n);
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check(tag, n, exp_n);
    endtask

    // Called right after a grant is observed; acks after rise_dly cycles,
    // drops ack three cycles after enable falls.
    task automatic ack_xfer(input int rise_dly, input logic [NUM_REQ-1:0] exp_done,
                            input logic [NUM_REQ-1:0] drop, input string tag);
        repeat (rise_dly) tick();
        ack_async = 1'b1;
        wait_en(1'b0, {tag, "_ack_lat"}, ACK_LAT);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_no_err"}, err, 0);
        req = req & ~drop;
        tick();
        check({tag, "_done_1cyc"}, done, 0);
        check({tag, "_release_busy"}, busy, 1);
        repeat (2) tick();
        ack_async = 1'b0;
        wait_idle({tag, "_rel_lat"}, ACK_LAT);
    endtask

    int rr_own[5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_tx_bus", tx_bus, 0);
        check("rst_tx_enable", tx_enable, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);
        check("rst_rr_ptr", dbg_rr_ptr, 0);
        RST = 1'b1;
        tick();
        check("idle_no_req", busy, 0);

        // Round-robin with all four requesting continuously
        set_word(0, 8'h10); set_word(1, 8'h21); set_word(2, 8'h32); set_word(3, 8'h43);
        exp_q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [BUS_WIDTH-1:0] exp_w;
            tick();
            exp_w = exp_q.pop_front();
            check("rr_enable", tx_enable, 1);
            check("rr_owner", owner, rr_own[i]);
            check("rr_tx_bus", tx_bus, exp_w);
            ack_xfer(3, 4'(1 << rr_own[i]), 4'b0000, "rr");
        end
        req = 4'b0000;
        check("rr_ptr_after", dbg_rr_ptr, 1);

        // Single request
        set_word(1, 8'hA5);
        req = 4'b0010;
        tick();
        check("single_enable", tx_enable, 1);
        check("single_tx_bus", tx_bus, 8'hA5);
        check("single_owner", owner, 1);
        check("single_busy", busy, 1);
        ack_xfer(3, 4'b0010, 4'b0010, "single");
        check("single_rr_ptr", dbg_rr_ptr, 2);
        check("single_bus_held", tx_bus, 8'hA5);
        check("single_owner_held", owner, 1);
        tick();
        check("single_no_regrant", busy, 0);

        // Reset mid-SEND
        set_word(0, 8'h5A); set_word(2, 8'h3C);
        req = 4'b0100;
        tick();
        check("mid_owner", owner, 2);
        check("mid_tx_bus", tx_bus, 8'h3C);
        repeat (2) tick();
        RST = 1'b0;
        #1;
        check("mid_rst_enable", tx_enable, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pulses", {done, err}, 0);
        check("mid_rst_owner", owner, 0);
        req = 4'b0001;
        tick();
        RST = 1'b1;
        tick();
        check("resume_enable", tx_enable, 1);
        check("resume_owner", owner, 0);
        check("resume_tx_bus", tx_bus, 8'h5A);
        ack_xfer(2, 4'b0001, 4'b0001, "resume");

        // Timeout
        set_word(3, 8'h77);
        req = 4'b1000;
        tick();
        check("to_owner", owner, 3);
        wait_en(1'b0, "to_enable_len", TIMEOUT);
        check("to_err", err, 4'b1000);
        check("to_no_done", done, 0);
        check("to_release", dbg_state, 2);
        req = 4'b0000;
        tick();
        check("to_idle", busy, 0);
        check("to_err_1cyc", err, 0);

        // Ack arrives exactly on the last timeout cycle
        set_word(0, 8'hC3);
        req = 4'b0001;
        tick();
        check("col_enable", tx_enable, 1);
        repeat (TIMEOUT - ACK_LAT) tick();
        ack_async = 1'b1;
        wait_en(1'b0, "col_lat", ACK_LAT);
        check("col_done", done, 4'b0001);
        check("col_no_err", err, 0);
        req = 4'b0000;
        tick();
        check("col_pulses_clear", {done, err}, 0);
        repeat (2) tick();
        ack_async = 1'b0;
        wait_idle("col_rel_lat", ACK_LAT);

        // Requester drops req right after its grant
        set_word(0, 8'h99);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        check("drop_owner", owner, 0);
        check("drop_tx_bus", tx_bus, 8'h99);
        ack_xfer(3, 4'b0001, 4'b0000, "drop");
        repeat (4) tick();
        check("drop_no_regrant", {busy, tx_enable}, 0);
        check("drop_bus_held", tx_bus, 8'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
